// File: rtl/sys_cmd_ctrl_pkg.sv
// rtl/sys_cmd_ctrl_pkg.sv - shared command codes, operand addresses and state encoding
package sys_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int REG_A = 0;
  localparam int REG_B = 1;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_WR_ADDR  = 4'd1;
  localparam logic [3:0] ST_WR_DATA  = 4'd2;
  localparam logic [3:0] ST_RD_ADDR  = 4'd3;
  localparam logic [3:0] ST_RD_WAIT  = 4'd4;
  localparam logic [3:0] ST_ALU_A    = 4'd5;
  localparam logic [3:0] ST_ALU_B    = 4'd6;
  localparam logic [3:0] ST_ALU_FN   = 4'd7;
  localparam logic [3:0] ST_ALU_WAIT = 4'd8;
  localparam logic [3:0] ST_TX_PUSH  = 4'd9;

  typedef enum logic [3:0] {
    IDLE     = ST_IDLE,
    WR_ADDR  = ST_WR_ADDR,
    WR_DATA  = ST_WR_DATA,
    RD_ADDR  = ST_RD_ADDR,
    RD_WAIT  = ST_RD_WAIT,
    ALU_A    = ST_ALU_A,
    ALU_B    = ST_ALU_B,
    ALU_FN   = ST_ALU_FN,
    ALU_WAIT = ST_ALU_WAIT,
    TX_PUSH  = ST_TX_PUSH
  } state_t;

endpackage

// File: rtl/sys_cmd_wait_timer.sv
// rtl/sys_cmd_wait_timer.sv - wait-cycle counter with terminal-count flag
module sys_cmd_wait_timer #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  // tc flags the last waiting cycle, so the wait lasts exactly MAX cycles
  assign tc = en && (cnt == W'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// rtl/sys_cmd_ctrl.sv - UART frame decoder driving register file, ALU and TX FIFO
module sys_cmd_ctrl
  import sys_cmd_ctrl_pkg::*;
#(
  parameter int Data_width    = 8,
  parameter int Address_width = 4,
  parameter int ALU_FUN_width = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [Data_width-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [Data_width-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic [Data_width-1:0]    ALU_OUT,
  input  logic                     OUT_VALID,
  input  logic                     FIFO_FULL,
  output logic [Address_width-1:0] Address,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [Data_width-1:0]    WrData,
  output logic                     ALU_EN,
  output logic [ALU_FUN_width-1:0] ALU_FUN,
  output logic                     CLK_GATE_EN,
  output logic [Data_width-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     timeout_err
);

  state_t                   state;
  logic [Address_width-1:0] addr_q;
  logic [Data_width-1:0]    result_q;
  logic                     in_wait;
  logic                     tmr_clr;
  logic                     tmr_tc;

  assign in_wait = (state == RD_WAIT) || (state == ALU_WAIT);
  assign tmr_clr = !in_wait;

  sys_cmd_wait_timer #(
    .MAX(TIMEOUT)
  ) u_wait_timer (
    .clk  (CLK),
    .rst_n(RST),
    .clr  (tmr_clr),
    .en   (in_wait),
    .tc   (tmr_tc)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      addr_q      <= '0;
      result_q    <= '0;
      Address     <= '0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      WrData      <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      ALU_EN      <= 1'b0;
      TX_D_VLD    <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              Data_width'(CMD_WR):     state <= WR_ADDR;
              Data_width'(CMD_RD):     state <= RD_ADDR;
              Data_width'(CMD_ALU_OP): state <= ALU_A;
              Data_width'(CMD_ALU_NOP): begin
                state       <= ALU_FN;
                CLK_GATE_EN <= 1'b1;
              end
              default: state <= IDLE;
            endcase
          end
        end

        WR_ADDR: begin
          if (RX_D_VLD) begin
            addr_q <= RX_P_DATA[Address_width-1:0];
            state  <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (RX_D_VLD) begin
            WrEn    <= 1'b1;
            Address <= addr_q;
            WrData  <= RX_P_DATA;
            state   <= IDLE;
          end
        end

        RD_ADDR: begin
          if (RX_D_VLD) begin
            RdEn    <= 1'b1;
            Address <= RX_P_DATA[Address_width-1:0];
            state   <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (RdData_Valid) begin
            result_q <= RdData;
            state    <= TX_PUSH;
          end else if (tmr_tc) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end

        ALU_A: begin
          if (RX_D_VLD) begin
            WrEn    <= 1'b1;
            Address <= Address_width'(REG_A);
            WrData  <= RX_P_DATA;
            state   <= ALU_B;
          end
        end

        ALU_B: begin
          if (RX_D_VLD) begin
            WrEn        <= 1'b1;
            Address     <= Address_width'(REG_B);
            WrData      <= RX_P_DATA;
            CLK_GATE_EN <= 1'b1;
            state       <= ALU_FN;
          end
        end

        ALU_FN: begin
          if (RX_D_VLD) begin
            ALU_EN  <= 1'b1;
            ALU_FUN <= RX_P_DATA[ALU_FUN_width-1:0];
            state   <= ALU_WAIT;
          end
        end

        ALU_WAIT: begin
          // a valid arriving on the terminal-count cycle still completes the command
          if (OUT_VALID) begin
            result_q    <= ALU_OUT;
            CLK_GATE_EN <= 1'b0;
            state       <= TX_PUSH;
          end else if (tmr_tc) begin
            timeout_err <= 1'b1;
            CLK_GATE_EN <= 1'b0;
            state       <= IDLE;
          end
        end

        TX_PUSH: begin
          if (!FIFO_FULL) begin
            TX_D_VLD  <= 1'b1;
            TX_P_DATA <= result_q;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sys_cmd_ctrl.md
Name: sys_cmd_ctrl

Overview:
- Command sequencer in the reference-clock domain of the system top.
- Consumes synchronized UART RX bytes and decodes the frame protocol: 0xAA reg-write, 0xBB reg-read, 0xCC ALU-with-operands, 0xDD ALU-no-operands.
- Drives the register file and ALU (including the ALU clock-gate enable).
- Pushes each one-byte result into the TX async FIFO.

Parameters:
- Data_width, 8, width of RX/TX bytes, register data and ALU result.
- Address_width, 4, register file address width.
- ALU_FUN_width, 4, ALU function select width.
- TIMEOUT, 255, max cycles to wait for RdData_Valid/OUT_VALID before abandoning a command.

Ports:
- CLK  in  1  reference clock.
- RST  in  1  asynchronous active-low reset.
- RX_P_DATA  in  Data_width  synchronized received byte.
- RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid.
- RdData  in  Data_width  register file read data.
- RdData_Valid  in  1  RdData valid pulse.
- ALU_OUT  in  Data_width  ALU result.
- OUT_VALID  in  1  ALU result valid pulse.
- FIFO_FULL  in  1  TX FIFO full.
- Address  out  Address_width  register file address.
- WrEn  out  1  register write strobe.
- RdEn  out  1  register read strobe.
- WrData  out  Data_width  register write data.
- ALU_EN  out  1  ALU start strobe.
- ALU_FUN  out  ALU_FUN_width  ALU function.
- CLK_GATE_EN  out  1  ALU clock gate enable.
- TX_P_DATA  out  Data_width  byte to TX FIFO.
- TX_D_VLD  out  1  TX FIFO write strobe.
- timeout_err  out  1  one-cycle pulse, command abandoned.

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs, the held address and the result register clear to 0.
- All outputs are registered. Strobes (WrEn, RdEn, ALU_EN, TX_D_VLD, timeout_err) are exactly one cycle wide and assert the cycle after the triggering input.
- IDLE, on RX_D_VLD:
  - 0xAA -> WR_ADDR
  - 0xBB -> RD_ADDR
  - 0xCC -> ALU_A
  - 0xDD -> ALU_FN
  - any other byte is ignored; remain IDLE.
- WR_ADDR: on RX_D_VLD, latch RX_P_DATA[Address_width-1:0] (upper bits dropped) -> WR_DATA.
- WR_DATA: on RX_D_VLD, WrEn=1, Address=latched, WrData=byte -> IDLE.
- RD_ADDR: on RX_D_VLD, RdEn=1, Address=byte[Address_width-1:0] -> RD_WAIT.
- RD_WAIT: on RdData_Valid, capture RdData into result register -> TX_PUSH.
- ALU_A: on RX_D_VLD, WrEn=1, Address=0, WrData=byte -> ALU_B.
- ALU_B: on RX_D_VLD, WrEn=1, Address=1, WrData=byte -> ALU_FN.
- ALU_FN: CLK_GATE_EN=1 throughout. On RX_D_VLD, ALU_EN=1, ALU_FUN=byte[ALU_FUN_width-1:0] -> ALU_WAIT.
- ALU_WAIT: CLK_GATE_EN=1. On OUT_VALID, capture ALU_OUT -> TX_PUSH; CLK_GATE_EN drops on entering TX_PUSH.
- TX_PUSH: when FIFO_FULL=0, TX_D_VLD=1 with TX_P_DATA=result -> IDLE. While FIFO_FULL=1, hold the state with no strobe. The result register is never overwritten while pending.
- Timeout: a wait counter clears on entering RD_WAIT/ALU_WAIT and increments each cycle. When it reaches TIMEOUT with no valid:
  - pulse timeout_err
  - return to IDLE with no push
  - clear CLK_GATE_EN.
- RX_D_VLD arriving in RD_WAIT, ALU_WAIT or TX_PUSH is dropped (no buffering).
- RdData_Valid/OUT_VALID outside the matching wait state is ignored.
- Simultaneous OUT_VALID and timeout terminal count: valid wins.
- Reset mid-command: aborts immediately, no strobes; the next frame decodes normally.

Decomposition:
- Shared package holds:
  - command constants CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD
  - operand addresses REG_A=0, REG_B=1
  - state encoding localparams.
- One natural sub-module: sys_cmd_wait_timer (load/clear, count-enable, terminal-count flag), shared by both wait states.

Test Plan:
- AA,05,55 -> one WrEn, Address=5, WrData=0x55. Then BB,05 with RdData=0x55 -> RdEn at Address=5, then one TX_D_VLD with TX_P_DATA=0x55.
- CC,0A,19,00 -> WrEn Address=0 WrData=0x0A, then WrEn Address=1 WrData=0x19, then ALU_EN with ALU_FUN=0 and CLK_GATE_EN=1. OUT_VALID with ALU_OUT=0x23 -> TX 0x23, CLK_GATE_EN=0.
- DD,0A -> no WrEn, ALU_EN with ALU_FUN=0xA. ALU_OUT=0x02 -> TX 0x02.
- Hold FIFO_FULL=1 when result 0x2A is ready, for 50 cycles -> no TX_D_VLD. After deassert, exactly one pulse with 0x2A.
- Byte 0x77 in IDLE is ignored. BB,03 with no RdData_Valid -> timeout_err after 255 cycles, IDLE, no TX; a following AA frame completes normally.
- Assert RST during ALU_WAIT -> all outputs 0 asynchronously. After release, DD,04 sequences correctly.
